// File: rtl/lmul_recon_if.sv
// Operand/result bundle for the shift-add reconstructor (numerator = q * d + r).
// The master drives the operands, and the slave (the reconstructor) returns results and pass-throughs.
interface lmul_recon_if #(
    parameter int unsigned QUOTIENT_WIDTH    = 10,
    parameter int unsigned DENOMINATOR_WIDTH = 10,
    parameter int unsigned NUMERATOR_WIDTH   = 10
) ();
    localparam int unsigned PRODUCT_WIDTH = QUOTIENT_WIDTH + DENOMINATOR_WIDTH + 1;

    logic [QUOTIENT_WIDTH-1:0]    quotient_in;
    logic [DENOMINATOR_WIDTH-1:0] denominator_in;
    logic [NUMERATOR_WIDTH-1:0]   remainder_in;
    logic                         valid_in;
    logic [PRODUCT_WIDTH-1:0]     numerator_out;
    logic                         overflow_out;
    logic                         valid_out;
    logic [QUOTIENT_WIDTH-1:0]    quotient_out;
    logic [DENOMINATOR_WIDTH-1:0] denominator_out;
    logic [NUMERATOR_WIDTH-1:0]   remainder_out;

    modport master (
        output quotient_in, denominator_in, remainder_in, valid_in,
        input  numerator_out, overflow_out, valid_out, quotient_out, denominator_out,
               remainder_out
    );

    modport slave (
        input  quotient_in, denominator_in, remainder_in, valid_in,
        output numerator_out, overflow_out, valid_out, quotient_out, denominator_out,
               remainder_out
    );
endinterface

// File: rtl/lmul_recon.sv
// Pipelined signed shift-add reconstructor, which computes numerator = quotient * denominator + remainder.
// Each stage adds one partial product, starting with the MSB. The sign is applied after the last stage.
module lmul_recon #(
    parameter int unsigned QUOTIENT_WIDTH    = 10,
    parameter int unsigned DENOMINATOR_WIDTH = 10,
    parameter int unsigned NUMERATOR_WIDTH   = 10
) (
    input logic          clk,
    input logic          reset,
    lmul_recon_if.slave  bus
);
    localparam int unsigned PRODUCT_WIDTH = QUOTIENT_WIDTH + DENOMINATOR_WIDTH + 1;
    localparam int unsigned LATENCY       = QUOTIENT_WIDTH + 1;
    localparam int unsigned QW            = QUOTIENT_WIDTH;
    localparam int unsigned DW            = DENOMINATOR_WIDTH;
    localparam int unsigned NW            = NUMERATOR_WIDTH;
    localparam int unsigned PW            = PRODUCT_WIDTH;
    localparam int unsigned LastStage     = LATENCY - 1;

    logic          valid_q [LATENCY];
    logic          valid_d [LATENCY];
    logic [PW-1:0] acc_q   [LATENCY];
    logic [PW-1:0] acc_d   [LATENCY];
    logic [QW-1:0] mag_q   [LATENCY];
    logic [QW-1:0] mag_d   [LATENCY];
    logic          sign_q  [LATENCY];
    logic          sign_d  [LATENCY];
    logic [DW-1:0] den_q   [LATENCY];
    logic [DW-1:0] den_d   [LATENCY];
    logic [NW-1:0] rem_q   [LATENCY];
    logic [NW-1:0] rem_d   [LATENCY];
    logic [QW-1:0] quo_q   [LATENCY];
    logic [QW-1:0] quo_d   [LATENCY];

    always_comb begin
        valid_d[0] = bus.valid_in;
        acc_d[0]   = '0;
        // The magnitude of -2^(QW-1) wraps to 2^(QW-1), which is still correct as unsigned.
        mag_d[0]   = bus.quotient_in[QW-1] ? -bus.quotient_in : bus.quotient_in;
        sign_d[0]  = bus.quotient_in[QW-1];
        den_d[0]   = bus.denominator_in;
        rem_d[0]   = bus.remainder_in;
        quo_d[0]   = bus.quotient_in;
        for (int k = 1; k < int'(LATENCY); k++) begin
            valid_d[k] = valid_q[k-1];
            acc_d[k]   = acc_q[k-1];
            if (mag_q[k-1][QW-k]) begin
                acc_d[k] = acc_q[k-1] + (PW'(den_q[k-1]) << (QW - k));
            end
            mag_d[k]  = mag_q[k-1];
            sign_d[k] = sign_q[k-1];
            den_d[k]  = den_q[k-1];
            rem_d[k]  = rem_q[k-1];
            quo_d[k]  = quo_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < int'(LATENCY); k++) begin
                valid_q[k] <= 1'b0;
                acc_q[k]   <= '0;
                mag_q[k]   <= '0;
                sign_q[k]  <= 1'b0;
                den_q[k]   <= '0;
                rem_q[k]   <= '0;
                quo_q[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < int'(LATENCY); k++) begin
                valid_q[k] <= valid_d[k];
                acc_q[k]   <= acc_d[k];
                mag_q[k]   <= mag_d[k];
                sign_q[k]  <= sign_d[k];
                den_q[k]   <= den_d[k];
                rem_q[k]   <= rem_d[k];
                quo_q[k]   <= quo_d[k];
            end
        end
    end

    logic [PW-1:0]    product;
    logic [PW-1:0]    rem_ext;
    logic [PW-1:0]    numerator;
    logic [PW-NW:0]   upper;
    logic             fits;

    always_comb begin
        product   = sign_q[LastStage] ? -acc_q[LastStage] : acc_q[LastStage];
        rem_ext   = {{(PW - NW){rem_q[LastStage][NW-1]}}, rem_q[LastStage]};
        numerator = product + rem_ext;
        // The value fits in NW signed bits only when all bits from NW-1 upward are identical.
        upper     = numerator[PW-1:NW-1];
        fits      = (&upper) | ~(|upper);

        bus.numerator_out   = numerator;
        bus.overflow_out    = valid_q[LastStage] & ~fits;
        bus.valid_out       = valid_q[LastStage];
        bus.quotient_out    = quo_q[LastStage];
        bus.denominator_out = den_q[LastStage];
        bus.remainder_out   = rem_q[LastStage];
    end
endmodule

// File: tb/tb_lmul_recon.sv
// Directed bench for lmul_recon. It checks reset, exact latency, streamed and gapped vectors,
// boundary operands, and mid-stream reset.
module tb_lmul_recon;
    localparam int unsigned QW = 10;
    localparam int unsigned DW = 10;
    localparam int unsigned NW = 10;
    localparam int          N  = 22;

    logic clk;
    logic reset;
    int   vectors     = 0;
    int   miscompares = 0;

    // Each entry holds valid, q, d, r, and the hand-computed numerator and overflow.
    int   tv [N] = '{1, 1, 1, 1, 0, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    int   tq [N] = '{7, -7, -512, -512, 100, 100, 0, 37, 0, 0, 511, -512, -1, 3, -85, 1, -1,
                     255, -341, -71, 0, -73};
    int   td [N] = '{13, 13, 1, 2, 10, 10, 55, 0, 0, 0, 1023, 1023, 1, 5, 6, 511, 511, 2, 3, 7,
                     1023, 7};
    int   tr [N] = '{5, -5, 0, 0, 11, 11, -3, -3, 0, 0, 511, -512, 511, -16, 2, 1, -2, 1, 0, -3,
                     511, 0};
    int   tn [N] = '{96, -96, -512, -1024, 0, 1011, -3, -3, 0, 0, 523264, -524288, 510, -1,
                     -508, 512, -513, 511, -1023, -500, 511, -511};
    int   to [N] = '{0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0};

    lmul_recon_if #(
        .QUOTIENT_WIDTH   (QW),
        .DENOMINATOR_WIDTH(DW),
        .NUMERATOR_WIDTH  (NW)
    ) bus ();

    lmul_recon #(
        .QUOTIENT_WIDTH   (QW),
        .DENOMINATOR_WIDTH(DW),
        .NUMERATOR_WIDTH  (NW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int q, input int d, input int r, input logic v);
        bus.quotient_in    = QW'(q);
        bus.denominator_in = DW'(d);
        bus.remainder_in   = NW'(r);
        bus.valid_in       = v;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".valid"}, 64'(bus.valid_out), 0);
        chk({tag, ".num"}, $signed(bus.numerator_out), 0);
        chk({tag, ".ovf"}, 64'(bus.overflow_out), 0);
        chk({tag, ".q"}, 64'(bus.quotient_out), 0);
        chk({tag, ".d"}, 64'(bus.denominator_out), 0);
        chk({tag, ".r"}, 64'(bus.remainder_out), 0);
    endtask

    task automatic check_out(input string tag, input int n, input int o, input int q,
                             input int d, input int r);
        chk({tag, ".valid"}, 64'(bus.valid_out), 1);
        chk({tag, ".num"}, $signed(bus.numerator_out), n);
        chk({tag, ".ovf"}, 64'(bus.overflow_out), o);
        chk({tag, ".q"}, $signed(bus.quotient_out), q);
        chk({tag, ".d"}, 64'(bus.denominator_out), d);
        chk({tag, ".r"}, $signed(bus.remainder_out), r);
    endtask

    // Issue one op and require it to appear after exactly QW+1 capture edges, for one cycle.
    task automatic single_op(input string tag, input int q, input int d, input int r,
                             input int n, input int o);
        drive(q, d, r, 1'b1);
        step();
        drive(0, 0, 0, 1'b0);
        for (int i = 1; i < int'(QW); i++) begin
            step();
            chk({tag, ".early"}, 64'(bus.valid_out), 0);
        end
        step();
        check_out(tag, n, o, q, d, r);
        step();
        chk({tag, ".after"}, 64'(bus.valid_out), 0);
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 1'b0);
        #1 reset = 1'b0;
        #1 check_zero("reset_async");
        step();
        step();
        check_zero("reset_held");
        reset = 1'b1;

        single_op("basic", 7, 13, 5, 96, 0);

        // Stream the table with no idle cycles between entries. Entries with valid=0 form gaps.
        for (int t = 0; t < N + int'(QW); t++) begin
            if (t < N) drive(tq[t], td[t], tr[t], tv[t][0]);
            else       drive(0, 0, 0, 1'b0);
            step();
            if (t >= int'(QW)) begin
                int j;
                j = t - int'(QW);
                if (tv[j] != 0) begin
                    check_out($sformatf("stream%0d", j), tn[j], to[j], tq[j], td[j], tr[j]);
                end else begin
                    chk($sformatf("gap%0d.valid", j), 64'(bus.valid_out), 0);
                    chk($sformatf("gap%0d.ovf", j), 64'(bus.overflow_out), 0);
                end
            end else begin
                chk("stream.fill", 64'(bus.valid_out), 0);
            end
        end

        // Load non-zero idle data into the pipe, then five live ops, then reset between edges.
        for (int i = 0; i < int'(QW); i++) begin
            drive(100, 10, 11, 1'b0);
            step();
        end
        for (int i = 0; i < 5; i++) begin
            drive(tq[i + 1], td[i + 1], tr[i + 1], 1'b1);
            step();
        end
        drive(0, 0, 0, 1'b0);
        #2 reset = 1'b0;
        #1 check_zero("midreset");
        step();
        step();
        check_zero("midreset_held");
        reset = 1'b1;
        for (int i = 0; i < int'(QW) + 2; i++) begin
            step();
            chk("discarded.valid", 64'(bus.valid_out), 0);
        end

        single_op("post_reset", -7, 13, -5, -96, 0);
        single_op("min_q", -512, 2, 0, -1024, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/lmul_recon.md
Name: lmul_recon

Overview:
- Pipelined signed shift-add reconstructor: computes numerator = quotient * denominator + remainder. It is the inverse of the team's pipelined long divider.
- Used to check or round-trip divider results, and to rebuild dividends after quotient/remainder manipulation.
- Fully pipelined, one operation accepted per clock, fixed latency, no backpressure.

Parameters:
- QUOTIENT_WIDTH, 10, signed quotient input width.
- DENOMINATOR_WIDTH, 10, unsigned denominator width.
- NUMERATOR_WIDTH, 10, signed remainder width; target width for the overflow check.
- PRODUCT_WIDTH (localparam), QUOTIENT_WIDTH + DENOMINATOR_WIDTH + 1, full signed result width.
- LATENCY (localparam), QUOTIENT_WIDTH + 1, valid_in to valid_out in cycles.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset; asserted while 0.
- quotient_in  in  QUOTIENT_WIDTH  signed quotient.
- denominator_in  in  DENOMINATOR_WIDTH  unsigned denominator.
- remainder_in  in  NUMERATOR_WIDTH  signed remainder.
- valid_in  in  1  input qualifier.
- numerator_out  out  PRODUCT_WIDTH  signed q*d + r.
- overflow_out  out  1  numerator_out is not representable in NUMERATOR_WIDTH signed.
- valid_out  out  1  output qualifier.
- quotient_out  out  QUOTIENT_WIDTH  quotient_in delayed LATENCY cycles.
- denominator_out  out  DENOMINATOR_WIDTH  denominator_in delayed LATENCY cycles.
- remainder_out  out  NUMERATOR_WIDTH  remainder_in delayed LATENCY cycles.

Behaviour:
- Pipeline stages 0..QUOTIENT_WIDTH. Every stage registers: valid, accumulator (PRODUCT_WIDTH), |q| (QUOTIENT_WIDTH, unsigned), quotient sign, denominator, remainder, original quotient.
- Stage 0 captures inputs:
  - |q| = -quotient_in when negative, else quotient_in. For -2^(QW-1) the magnitude 2^(QW-1) fits in QW unsigned bits.
  - Accumulator = 0.
- Stage k (1..QUOTIENT_WIDTH): if |q| bit (QW-k) of stage k-1 is 1, accumulator += denominator << (QW-k), zero-extended. Otherwise the accumulator passes unchanged. Processing is MSB first.
- Output is combinational from the last stage:
  - signed_product = sign ? -acc : acc.
  - numerator_out = signed_product + sign-extended remainder.
  - Sized to PRODUCT_WIDTH, so no wrap is possible.
- overflow_out = 1 when numerator_out < -2^(NW-1) or > 2^(NW-1)-1. Qualified by valid_out; it is 0 whenever valid_out = 0.
- Data fields advance every cycle regardless of valid. Outputs are don't-care for checking when valid_out = 0, but must be deterministic.
- Latency is exactly LATENCY cycles: valid_in high at edge N gives valid_out high after edge N+QUOTIENT_WIDTH.
- Throughput is one per cycle. Back-to-back operations are independent, with no inter-stage hazards.
- denominator = 0: result = remainder. quotient = 0: result = remainder. These are not error cases.
- Remainder sign is used as given; it is not required to match the quotient sign.
- Reset assertion (async, immediate):
  - Every stage's valid and data registers clear to 0.
  - Hence valid_out = 0, numerator_out = 0, overflow_out = 0, and the pass-through outputs are 0.
  - In-flight operations are discarded, not completed.
- Reset release: the first valid_out follows the first valid_in after release by exactly LATENCY cycles. No spurious valid pulses occur.
- No state machine beyond the valid shift chain. No stall or flush input exists.

Test Plan:
- q=7, d=13, r=5, single valid pulse -> exactly 11 cycles later valid_out=1 for one cycle, numerator_out=96, overflow_out=0, pass-throughs 7/13/5.
- q=-7, d=13, r=-5 -> numerator_out=-96; q=-512, d=1, r=0 -> -512, overflow_out=0; q=-512, d=2, r=0 -> -1024, overflow_out=1.
- q=100, d=10, r=11 -> numerator_out=1011, overflow_out=1; q=0 or d=0 with r=-3 -> -3, overflow_out=0.
- 200 back-to-back random (q, d, r) with valid every cycle, plus gapped valids -> every output matches the reference model in order, valid_out pattern equals valid_in delayed 11 cycles.
- Divider round trip: random numerator n through the divider, quotient/denominator/remainder fed here -> numerator_out == n for all n in [-512, 511] with d in [1, 1023].
- Reset pulsed low mid-stream with 5 ops in flight -> outputs go 0 immediately without a clock, no valid_out for the discarded ops, new op after release emerges at exactly 11 cycles.
